// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package tx_arbiter_pkg;

  localparam int DEPTH_DEF = 4;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

endpackage

// File: rtl/tx_arbiter_byte_fifo.sv
// Byte FIFO with power-of-2 depth; writes while full are ignored.
module byte_fifo #(
  parameter int DEPTH = tx_arbiter_pkg::DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding encoder/decoder bytes to one UART transmitter.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_ready,
  input  logic [7:0] enc_byte,
  input  logic       dec_ready,
  input  logic [7:0] dec_byte,
  input  logic       tx_busy,
  output logic       tx_enable,
  output logic [7:0] tx_byte,
  output logic       enc_full,
  output logic       dec_full,
  output logic [1:0] overflow,
  output logic       timeout,
  output logic       idle
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic [7:0]    enc_dout, dec_dout;
  logic          enc_empty, dec_empty;
  logic [CW-1:0] enc_cnt, dec_cnt;
  logic          enc_pop, dec_pop;
  logic          enc_req, dec_req, win;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          who_q, who_d;
  logic [7:0]    byte_q, byte_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          to_q, to_d;

  byte_fifo #(.DEPTH(DEPTH)) u_enc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enc_ready),
    .pop   (enc_pop),
    .din   (enc_byte),
    .dout  (enc_dout),
    .full  (enc_full),
    .empty (enc_empty),
    .count (enc_cnt)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_dec_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dec_ready),
    .pop   (dec_pop),
    .din   (dec_byte),
    .dout  (dec_dout),
    .full  (dec_full),
    .empty (dec_empty),
    .count (dec_cnt)
  );

  assign enc_req = enc_cnt != '0;
  assign dec_req = dec_cnt != '0;
  assign win     = (enc_req && dec_req) ? ~last_q
                 : (enc_req ? ENC : DEC);
  assign enc_pop = (state_q == ST_LOAD) && (who_q == ENC);
  assign dec_pop = (state_q == ST_LOAD) && (who_q == DEC);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    who_d     = who_q;
    byte_d    = byte_q;
    tmr_d     = tmr_q;
    to_d      = to_q;
    tx_enable = 1'b0;
    ovf_d     = ovf_q | {dec_ready && dec_full,
                         enc_ready && enc_full};
    unique case (state_q)
      ST_IDLE: begin
        if ((enc_req || dec_req) && !tx_busy) begin
          state_d = ST_LOAD;
          who_d   = win;
          byte_d  = (win == ENC) ? enc_dout : dec_dout;
          // Only contested grants move the turn; a lone requester keeps it.
          if (enc_req && dec_req) last_d = win;
        end
      end
      ST_LOAD: begin
        tx_enable = 1'b1;
        tmr_d     = '0;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= DEC;
      who_q   <= ENC;
      byte_q  <= '0;
      tmr_q   <= '0;
      ovf_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      who_q   <= who_d;
      byte_q  <= byte_d;
      tmr_q   <= tmr_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign tx_byte  = byte_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;
  assign idle     = (state_q == ST_IDLE) && enc_empty && dec_empty;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized and directed bench for tx_arbiter against a queue-based model.
module tb_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_ready, dec_ready, tx_busy;
  logic [7:0] enc_byte, dec_byte;
  logic       tx_enable;
  logic [7:0] tx_byte;
  logic       enc_full, dec_full;
  logic [1:0] overflow;
  logic       timeout, idle;

  tx_arbiter #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_ready (enc_ready),
    .enc_byte  (enc_byte),
    .dec_ready (dec_ready),
    .dec_byte  (dec_byte),
    .tx_busy   (tx_busy),
    .tx_enable (tx_enable),
    .tx_byte   (tx_byte),
    .enc_full  (enc_full),
    .dec_full  (dec_full),
    .overflow  (overflow),
    .timeout   (timeout),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: two byte queues plus frame bookkeeping.
  logic [7:0] eq[$];
  logic [7:0] dq[$];
  logic [7:0] m_byte;
  logic [1:0] m_ovf;
  bit m_last, m_who, m_pend, m_wait, m_done, m_frame, m_to;
  int m_cnt;

  logic [7:0] sent[$];

  // Transmitter behaviour
  bit force_busy, uart_ack, rnd;
  int ack_delay, hold_len, u_cd, u_hold;

  function automatic void m_reset();
    eq.delete();
    dq.delete();
    m_byte = '0; m_ovf = '0;
    m_last = 1'b1; m_who = 1'b0;
    m_pend = 0; m_wait = 0; m_done = 0;
    m_frame = 0; m_to = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit er, input logic [7:0] eb,
                                     input bit dr, input logic [7:0] db,
                                     input bit busy);
    int es = eq.size();
    int ds = dq.size();
    if (m_pend) begin
      if (m_who) void'(dq.pop_front());
      else void'(eq.pop_front());
      m_pend = 0; m_wait = 1; m_cnt = 0;
    end else if (m_wait) begin
      if (busy) begin
        m_wait = 0; m_done = 1;
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_wait = 0; m_frame = 0; m_to = 1;
        end
      end
    end else if (m_done) begin
      if (!busy) begin
        m_done = 0; m_frame = 0;
      end
    end else if (!busy && (es > 0 || ds > 0)) begin
      if (es > 0 && ds > 0) begin
        m_who = !m_last;
        m_last = m_who;
      end else begin
        m_who = (es > 0) ? 1'b0 : 1'b1;
      end
      m_byte = m_who ? dq[0] : eq[0];
      m_pend = 1; m_frame = 1;
    end
    if (er) begin
      if (es == DEPTH) m_ovf[0] = 1'b1;
      else eq.push_back(eb);
    end
    if (dr) begin
      if (ds == DEPTH) m_ovf[1] = 1'b1;
      else dq.push_back(db);
    end
  endfunction

  function automatic logic [7:0] sent_at(input int i);
    return (i < sent.size()) ? sent[i] : 8'hxx;
  endfunction

  task automatic cycle(input bit er, input logic [7:0] eb,
                       input bit dr, input logic [7:0] db);
    bit busy;
    chk("tx_enable", tx_enable, m_pend);
    chk("tx_byte", tx_byte, m_byte);
    chk("enc_full", enc_full, eq.size() == DEPTH);
    chk("dec_full", dec_full, dq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("timeout", timeout, m_to);
    chk("idle", idle, !m_frame && eq.size() == 0 && dq.size() == 0);
    if (tx_enable) sent.push_back(tx_byte);
    if (m_pend) begin
      if (rnd) begin
        uart_ack  = $urandom_range(0, 7) != 0;
        ack_delay = $urandom_range(2, 4);
        hold_len  = $urandom_range(1, 8);
      end
      if (uart_ack) u_cd = ack_delay;
    end
    busy = force_busy;
    if (u_hold > 0) begin
      busy = 1; u_hold--;
    end else if (u_cd > 0) begin
      u_cd--;
      if (u_cd == 0) begin
        busy = 1; u_hold = hold_len - 1;
      end
    end
    enc_ready = er; enc_byte = eb;
    dec_ready = dr; dec_byte = db;
    tx_busy = busy;
    model_step(er, eb, dr, db, busy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_enc_full", enc_full, 0);
    chk("rst_dec_full", dec_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_idle", idle, 1);
    enc_ready = 0; dec_ready = 0; tx_busy = 0;
    force_busy = 0; u_cd = 0; u_hold = 0;
    uart_ack = 1; ack_delay = 2; hold_len = 3; rnd = 0;
    m_reset();
    sent.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((m_frame || eq.size() > 0 || dq.size() > 0) && k < max) begin
      cycle(0, 8'h00, 0, 8'h00);
      k++;
    end
    chk("drain_idle", idle, 1);
  endtask

  initial begin
    reset = 1'b1;
    enc_ready = 0; dec_ready = 0; tx_busy = 0;
    enc_byte = 0; dec_byte = 0;
    @(negedge clk);

    // Single byte
    do_reset();
    ack_delay = 2; hold_len = 10;
    cycle(1, 8'h31, 0, 8'h00);
    for (int i = 0; i < 20; i++) cycle(0, 8'h00, 0, 8'h00);
    chk("single_cnt", sent.size(), 1);
    chk("single_byte", sent_at(0), 8'h31);
    chk("single_idle", idle, 1);

    // Ties
    do_reset();
    cycle(1, 8'hA1, 1, 8'hB1);
    drain(60);
    chk("tie1_first", sent_at(0), 8'hA1);
    chk("tie1_second", sent_at(1), 8'hB1);
    sent.delete();
    cycle(1, 8'hA2, 1, 8'hB2);
    drain(60);
    chk("tie2_first", sent_at(0), 8'hB2);
    chk("tie2_second", sent_at(1), 8'hA2);

    // Overflow
    do_reset();
    force_busy = 1; hold_len = 2;
    for (int i = 1; i <= 5; i++) cycle(1, 8'(i), 0, 8'h00);
    cycle(0, 8'h00, 0, 8'h00);
    chk("ovf_full", enc_full, 1);
    chk("ovf_flag", overflow, 2'b01);
    force_busy = 0;
    drain(150);
    chk("ovf_cnt", sent.size(), 4);
    for (int i = 0; i < 4; i++) chk("ovf_order", sent_at(i), 8'(i + 1));

    // Timeout
    do_reset();
    uart_ack = 0;
    cycle(1, 8'h55, 0, 8'h00);
    cycle(1, 8'h56, 0, 8'h00);
    for (int k = 0; k < 40 && timeout !== 1'b1; k++)
      cycle(0, 8'h00, 0, 8'h00);
    chk("to_set", timeout, 1);
    uart_ack = 1;
    drain(80);
    chk("to_cnt", sent.size(), 2);
    chk("to_next", sent_at(1), 8'h56);

    // Reset during WAIT_DONE with bytes queued
    do_reset();
    hold_len = 30;
    cycle(1, 8'h11, 1, 8'h21);
    cycle(1, 8'h12, 1, 8'h22);
    for (int k = 0; k < 20 && !m_done; k++) cycle(0, 8'h00, 0, 8'h00);
    chk("mid_busy", idle, 0);
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 8'h00, 0, 8'h00);
    chk("mid_no_grant", sent.size(), 0);

    // Pointer wrap
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'h80 + 8'(i), 0, 8'h00);
      drain(40);
    end
    chk("wrap_cnt", sent.size(), 12);
    for (int i = 0; i < 12; i++)
      chk("wrap_order", sent_at(i), 8'h80 + 8'(i));

    // Random traffic
    do_reset();
    rnd = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) force_busy = !force_busy;
      cycle($urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 3) == 0, 8'($urandom));
    end
    rnd = 0;
    force_busy = 0;
    uart_ack = 1;
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
